alu_issue_stage: RTL

- ID/EX issue register that drives the execute-stage ALU.
- Decodes the instruction word into the 6-bit ALU operation code and selects the A, B and C operands from register-file data and immediates.
- Registers the result into the ID/EX boundary with stall, flush and valid control.
- Keeps a saturating count of issued operations and an illegal-opcode flag for debug.

---
 rtl/alu_issue_stage_if.sv | 29 ++
 rtl/alu_issue_stage.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_issue_stage_if.sv
// ID/EX issue-stage bundle: decode-side inputs, control, and registered outputs.
// The slave modport is the stage itself; the master modport drives it.
interface alu_issue_stage_if #(
    parameter int CNT_W = 16
);
    logic             In_Valid;
    logic [31:0]      Instruction;
    logic [31:0]      RsData;
    logic [31:0]      RtData;
    logic             Stall;
    logic             Flush;
    logic             Out_Valid;
    logic [5:0]       ALUControl;
    logic [31:0]      A;
    logic [31:0]      B;
    logic [31:0]      C;
    logic             Illegal;
    logic [CNT_W-1:0] OpCount;

    modport slave (
        input  In_Valid, Instruction, RsData, RtData, Stall, Flush,
        output Out_Valid, ALUControl, A, B, C, Illegal, OpCount
    );

    modport master (
        output In_Valid, Instruction, RsData, RtData, Stall, Flush,
        input  Out_Valid, ALUControl, A, B, C, Illegal, OpCount
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes the instruction into an ALU op and operands,
// registers them with flush/stall/valid control and keeps a saturating issue count.
module alu_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    alu_issue_stage_if.slave   bus
);
    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic [4:0]       w_shamt;
    logic [31:0]      w_se;
    logic [31:0]      w_ze;
    logic [5:0]       w_ctrl;
    logic [31:0]      w_a;
    logic [31:0]      w_b;
    logic [31:0]      w_c;
    logic             w_illegal;

    logic             r_valid;
    logic [5:0]       r_ctrl;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_c;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    assign w_op    = bus.Instruction[31:26];
    assign w_funct = bus.Instruction[5:0];
    assign w_shamt = bus.Instruction[10:6];
    assign w_se    = {{16{bus.Instruction[15]}}, bus.Instruction[15:0]};
    assign w_ze    = {16'h0000, bus.Instruction[15:0]};

    // Undecodable encodings fall through to an all-zero add flagged as illegal.
    always_comb begin
        w_ctrl    = 6'd0;
        w_a       = 32'h0;
        w_b       = 32'h0;
        w_c       = 32'h0;
        w_illegal = 1'b0;
        case (w_op)
            6'h00: begin
                w_a = bus.RsData;
                w_b = bus.RtData;
                case (w_funct)
                    6'h20: w_ctrl = 6'd0;
                    6'h22: w_ctrl = 6'd1;
                    6'h24: w_ctrl = 6'd3;
                    6'h25: w_ctrl = 6'd4;
                    6'h27: w_ctrl = 6'd5;
                    6'h26: w_ctrl = 6'd6;
                    6'h2A: w_ctrl = 6'd9;
                    6'h08: w_b    = 32'h0;
                    6'h00, 6'h02: begin
                        w_ctrl = (w_funct == 6'h00) ? 6'd7 : 6'd8;
                        w_a    = 32'h0;
                        w_c    = {21'b0, w_shamt, 6'b0};
                    end
                    default: begin
                        w_a       = 32'h0;
                        w_b       = 32'h0;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            6'h1C: begin
                if (w_funct == 6'h02) begin
                    w_ctrl = 6'd2;
                    w_a    = bus.RsData;
                    w_b    = bus.RtData;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            6'h08, 6'h23, 6'h2B: begin
                w_a = bus.RsData;
                w_b = w_se;
            end
            6'h0A: begin
                w_ctrl = 6'd9;
                w_a    = bus.RsData;
                w_b    = w_se;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                w_ctrl = (w_op == 6'h0C) ? 6'd3 : ((w_op == 6'h0D) ? 6'd4 : 6'd6);
                w_a    = bus.RsData;
                w_b    = w_ze;
            end
            6'h04, 6'h05: begin
                w_ctrl = 6'd1;
                w_a    = bus.RsData;
                w_b    = bus.RtData;
            end
            6'h02, 6'h03: w_ctrl = 6'd0;
            default: w_illegal = 1'b1;
        endcase
    end

    // Flush beats stall; a bubble clears everything except the issue count.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid   <= 1'b0;
            r_ctrl    <= 6'd0;
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_c       <= 32'h0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (bus.Flush || (!bus.Stall && !bus.In_Valid)) begin
            r_valid   <= 1'b0;
            r_ctrl    <= 6'd0;
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_c       <= 32'h0;
            r_illegal <= 1'b0;
        end else if (!bus.Stall) begin
            r_valid   <= 1'b1;
            r_ctrl    <= w_ctrl;
            r_a       <= w_a;
            r_b       <= w_b;
            r_c       <= w_c;
            r_illegal <= w_illegal;
            if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.Out_Valid  = r_valid;
    assign bus.ALUControl = r_ctrl;
    assign bus.A          = r_a;
    assign bus.B          = r_b;
    assign bus.C          = r_c;
    assign bus.Illegal    = r_illegal;
    assign bus.OpCount    = r_cnt;
endmodule
